// File: rtl/port_walk_seq.sv
// rtl/port_walk_seq.sv - walking-one/zero self-checking sequencer for a pass-through port datapath
module port_walk_seq #(
  parameter int WIDTH = 8,
  parameter int LAT   = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         walk_zero,
  input  logic                         abort,
  output logic [WIDTH-1:0]             dut_in,
  input  logic [WIDTH-1:0]             dut_out,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [$clog2(WIDTH+1)-1:0]   err_count,
  output logic                         fail_valid,
  output logic [$clog2(WIDTH)-1:0]     fail_idx
);

  localparam int CW = $clog2(WIDTH+1);
  localparam int IW = $clog2(WIDTH);
  localparam logic [3:0]    LAT_W  = 4'(LAT);
  localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] dut_in_q, dut_in_d;
  logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [CW-1:0]   err_q, err_d;
  logic            fv_q, fv_d;
  logic [IW-1:0]   fidx_q, fidx_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic            mode_q, mode_d;
  logic            mismatch;

  function automatic logic [WIDTH-1:0] pattern(input logic m, input logic [IW-1:0] k);
    logic [WIDTH-1:0] one_hot;
    one_hot = {{(WIDTH-1){1'b0}}, 1'b1} << k;
    return m ? ~one_hot : one_hot;
  endfunction

  always_comb begin
    state_d  = state_q;
    dut_in_d = dut_in_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fv_d     = fv_q;
    fidx_d   = fidx_q;
    idx_d    = idx_q;
    wcnt_d   = wcnt_q;
    mode_d   = mode_q;
    // Defaulting to 1 makes an X/Z on dut_out count as a mismatch.
    mismatch = 1'b1;
    if (dut_out == dut_in_q) mismatch = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mode_d   = walk_zero;
          idx_d    = '0;
          wcnt_d   = LAT_W;
          err_d    = '0;
          fv_d     = 1'b0;
          fidx_d   = '0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          dut_in_d = pattern(walk_zero, '0);
          state_d  = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          dut_in_d = '0;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          if (mismatch) begin
            err_d = err_q + CW'(1);
            if (!fv_q) begin
              fv_d   = 1'b1;
              fidx_d = idx_q;
            end
          end
          if (idx_q == IDX_MAX) begin
            dut_in_d = '0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            pass_d   = (err_d == '0);
            state_d  = DONE;
          end else begin
            idx_d    = idx_q + IW'(1);
            dut_in_d = pattern(mode_q, idx_q + IW'(1));
            wcnt_d   = LAT_W;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      fidx_q   <= '0;
      idx_q    <= '0;
      wcnt_q   <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dut_in_q <= dut_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      fidx_q   <= fidx_d;
      idx_q    <= idx_d;
      wcnt_q   <= wcnt_d;
      mode_q   <= mode_d;
    end
  end

  assign dut_in     = dut_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_idx   = fidx_q;

endmodule

// File: tb/tb_port_walk_seq.sv
// tb/tb_port_walk_seq.sv - directed bench for port_walk_seq with LAT=0 and LAT=1 instances
module tb_port_walk_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, wz0, abort0, start1, wz1, abort1;
  logic [1:0] sel0;
  logic [7:0] dut_in0, dut_out0, dut_in1, dut_out1, reg0, reg1;
  logic       busy0, done0, pass0, fv0, busy1, done1, pass1, fv1;
  logic [3:0] err0, err1;
  logic [2:0] fidx0, fidx1;
  logic [7:0] exp8;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    reg0 <= dut_in0;
    reg1 <= dut_in1;
  end

  // sel0: 0 = wire loopback, 1 = bit 3 stuck-at-0, 2 = one-stage registered loopback
  always_comb begin
    dut_out0 = dut_in0;
    if (sel0 == 2'd1) dut_out0 = dut_in0 & 8'hF7;
    else if (sel0 == 2'd2) dut_out0 = reg0;
  end
  assign dut_out1 = reg1;

  port_walk_seq #(.WIDTH(8), .LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .walk_zero(wz0), .abort(abort0),
    .dut_in(dut_in0), .dut_out(dut_out0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_valid(fv0), .fail_idx(fidx0)
  );

  port_walk_seq #(.WIDTH(8), .LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .walk_zero(wz1), .abort(abort1),
    .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .fail_idx(fidx1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_dut_in"}, 32'(dut_in0), 0);
    check({tag, "_busy"}, 32'(busy0), 0);
    check({tag, "_done"}, 32'(done0), 0);
    check({tag, "_pass"}, 32'(pass0), 0);
    check({tag, "_err"}, 32'(err0), 0);
    check({tag, "_fv"}, 32'(fv0), 0);
    check({tag, "_fidx"}, 32'(fidx0), 0);
  endtask

  initial begin
    rst_n = 1'b0; start0 = 0; wz0 = 0; abort0 = 0; sel0 = 0;
    start1 = 0; wz1 = 0; abort1 = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset0("rst");
    check("rst_busy1", 32'(busy1), 0);
    rst_n = 1'b1;
    tick(1);

    // walking one, wire loopback, LAT=0
    start0 = 1; tick(1); start0 = 0;
    for (int k = 0; k < 8; k++) begin
      exp8 = 8'h01 << k;
      check("w1_dut_in", 32'(dut_in0), 32'(exp8));
      check("w1_busy", 32'(busy0), 1);
      tick(1);
    end
    check("w1_done", 32'(done0), 1);
    check("w1_busy_off", 32'(busy0), 0);
    check("w1_pass", 32'(pass0), 1);
    check("w1_err", 32'(err0), 0);
    check("w1_fv", 32'(fv0), 0);
    check("w1_dut_in_0", 32'(dut_in0), 0);

    // walking zero, registered loopback, LAT=1
    wz1 = 1; start1 = 1; tick(1); start1 = 0;
    for (int c = 0; c < 16; c++) begin
      exp8 = ~(8'h01 << (c / 2));
      check("w0_dut_in", 32'(dut_in1), 32'(exp8));
      tick(1);
    end
    check("w0_done", 32'(done1), 1);
    check("w0_pass", 32'(pass1), 1);
    check("w0_err", 32'(err1), 0);

    // registered loopback against LAT=0: every pattern mismatches
    sel0 = 2; wz0 = 1; start0 = 1; tick(1); start0 = 0;
    check("reg_done_clr", 32'(done0), 0);
    check("reg_pass_clr", 32'(pass0), 0);
    tick(8);
    check("reg_done", 32'(done0), 1);
    check("reg_err", 32'(err0), 8);
    check("reg_fv", 32'(fv0), 1);
    check("reg_fidx", 32'(fidx0), 0);
    check("reg_pass", 32'(pass0), 0);

    // bit 3 stuck-at-0
    sel0 = 1; wz0 = 0; start0 = 1; tick(1); start0 = 0;
    check("stk_fv_clr", 32'(fv0), 0);
    check("stk_err_clr", 32'(err0), 0);
    tick(8);
    check("stk_done", 32'(done0), 1);
    check("stk_err", 32'(err0), 1);
    check("stk_fv", 32'(fv0), 1);
    check("stk_fidx", 32'(fidx0), 3);
    check("stk_pass", 32'(pass0), 0);

    // abort in DONE has no effect
    sel0 = 0; abort0 = 1; tick(1); abort0 = 0;
    check("abort_done_hold", 32'(done0), 1);
    check("abort_err_hold", 32'(err0), 1);

    // abort sampled at the end of the 4th RUN cycle
    start0 = 1; tick(1); start0 = 0;
    tick(3);
    check("ab_pre_dut_in", 32'(dut_in0), 32'h08);
    abort0 = 1; tick(1); abort0 = 0;
    check("ab_busy", 32'(busy0), 0);
    check("ab_done", 32'(done0), 0);
    check("ab_dut_in", 32'(dut_in0), 0);
    check("ab_pass", 32'(pass0), 0);
    tick(1);
    check("ab_idle", 32'(busy0), 0);

    // start and abort together in IDLE: start wins
    start0 = 1; abort0 = 1; tick(1); start0 = 0; abort0 = 0;
    check("sa_busy", 32'(busy0), 1);
    check("sa_dut_in", 32'(dut_in0), 32'h01);
    tick(8);
    check("sa_done", 32'(done0), 1);
    check("sa_pass", 32'(pass0), 1);

    // asynchronous reset mid-sweep, not edge aligned
    sel0 = 1; start0 = 1; tick(1); start0 = 0;
    tick(5);
    check("ar_err_pre", 32'(err0), 1);
    #3 rst_n = 1'b0;
    #1;
    check_reset0("ar");
    #2 rst_n = 1'b1;
    tick(1);
    check("ar_no_resume_busy", 32'(busy0), 0);
    check("ar_no_resume_dut_in", 32'(dut_in0), 0);

    // start pulses during RUN are ignored
    sel0 = 0; start0 = 1; tick(1); start0 = 0;
    tick(2);
    start0 = 1; tick(1); start0 = 0;
    tick(4);
    check("ign_busy", 32'(busy0), 1);
    check("ign_done_early", 32'(done0), 0);
    tick(1);
    check("ign_done", 32'(done0), 1);
    check("ign_pass", 32'(pass0), 1);

    // start held high: back-to-back sweeps, period 17 at LAT=1
    wz1 = 0; start1 = 1; tick(1);
    tick(16);
    check("b2b_done1", 32'(done1), 1);
    check("b2b_pass1", 32'(pass1), 1);
    check("b2b_busy1", 32'(busy1), 0);
    tick(1);
    check("b2b_restart_busy", 32'(busy1), 1);
    check("b2b_restart_done", 32'(done1), 0);
    check("b2b_restart_dut_in", 32'(dut_in1), 32'h01);
    tick(16);
    check("b2b_done2", 32'(done1), 1);
    check("b2b_pass2", 32'(pass1), 1);
    start1 = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
